// File: rtl/iob_ram_sp_bist_if.sv
// iob_ram_sp_bist_if: single-port RAM access bus between the BIST (master) and the RAM (slave)
interface iob_ram_sp_bist_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic en;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  modport master(output en, we, addr, din, input dout);
  modport slave(input en, we, addr, din, output dout);
endinterface

// File: rtl/iob_ram_sp_bist.sv
// iob_ram_sp_bist: single-port RAM self-test (write seed+i, read back, compare); IOB_RAM_SP_BIST_INV_EN adds an inverted second pass
module iob_ram_sp_bist #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [DATA_W-1:0] seed,
  output logic busy,
  output logic done,
  output logic pass,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data,
  iob_ram_sp_bist_if.master ram
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = '1;
  state_t state;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] chk_exp;
  logic [ADDR_W-1:0] chk_addr;
  logic [ADDR_W-1:0] nxt_addr;
  logic chk_vld;
  logic mis;
  logic last;
`ifdef IOB_RAM_SP_BIST_INV_EN
  logic phase;
`else
  localparam logic phase = 1'b0;
`endif
  function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] s, input logic [ADDR_W-1:0] i, input logic inv);
    logic [DATA_W-1:0] v;
    v = s + DATA_W'(i);
    return inv ? ~v : v;
  endfunction
  assign mis = chk_vld && (ram.dout != chk_exp);
  assign last = ram.addr == LAST;
  assign nxt_addr = ram.addr + ADDR_W'(1);
  // Sequencer: walks WRITE/READ/CHECK, drives the RAM port, and records the first mismatch
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_addr <= '0;
      err_data <= '0;
      seed_q <= '0;
      chk_vld <= 1'b0;
      chk_addr <= '0;
      chk_exp <= '0;
      ram.en <= 1'b0;
      ram.we <= 1'b0;
      ram.addr <= '0;
      ram.din <= '0;
`ifdef IOB_RAM_SP_BIST_INV_EN
      phase <= 1'b0;
`endif
    end else begin
      chk_vld <= (state == READ) && !mis;
      chk_addr <= ram.addr;
      chk_exp <= pat(seed_q, ram.addr, phase);
      case (state)
        IDLE: if (start) begin
          state <= WRITE;
          busy <= 1'b1;
          done <= 1'b0;
          pass <= 1'b0;
          err_addr <= '0;
          err_data <= '0;
          seed_q <= seed;
          ram.en <= 1'b1;
          ram.we <= 1'b1;
          ram.addr <= '0;
          ram.din <= seed;
`ifdef IOB_RAM_SP_BIST_INV_EN
          phase <= 1'b0;
`endif
        end
        WRITE: begin
          ram.we <= !last;
          ram.addr <= last ? '0 : nxt_addr;
          ram.din <= last ? '0 : pat(seed_q, nxt_addr, phase);
          if (last) state <= READ;
        end
        READ, CHECK: if (mis) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          pass <= 1'b0;
          err_addr <= chk_addr;
          err_data <= ram.dout;
          ram.en <= 1'b0;
          ram.addr <= '0;
        end else if (state == READ) begin
          ram.en <= !last;
          ram.addr <= last ? '0 : nxt_addr;
          if (last) state <= CHECK;
        end else begin
`ifdef IOB_RAM_SP_BIST_INV_EN
          if (!phase) begin
            phase <= 1'b1;
            state <= WRITE;
            ram.en <= 1'b1;
            ram.we <= 1'b1;
            ram.addr <= '0;
            ram.din <= ~seed_q;
          end else begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= 1'b1;
          end
`else
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          pass <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iob_ram_sp_bist.sv
// tb_iob_ram_sp_bist: scoreboard bench for iob_ram_sp_bist driving a 1-cycle behavioural RAM
module tb_iob_ram_sp_bist;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int N = 16;
`ifdef IOB_RAM_SP_BIST_INV_EN
  localparam logic INV = 1'b1;
  localparam int CLEAN = 4 * N + 3;
`else
  localparam logic INV = 1'b0;
  localparam int CLEAN = 2 * N + 2;
`endif
  typedef struct {
    logic p;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int e;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [DW-1:0] seed = '0;
  logic busy, done, pass;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_data;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] rdata = '0;
  logic done_q = 1'b0;
  logic fault_on = 1'b0;
  logic [AW-1:0] fault_addr = '0;
  int fault_nth = 1;
  int fault_base = 0;
  int hits = 0;
  int edges = 0;
  int t0 = 0;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  iob_ram_sp_bist_if #(.DATA_W(DW), .ADDR_W(AW)) ram_if();
  iob_ram_sp_bist #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .seed(seed),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_addr(err_addr),
    .err_data(err_data),
    .ram(ram_if.master)
  );
  assign ram_if.dout = rdata;
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;
  always @(posedge clk) begin
    if (ram_if.en) begin
      if (ram_if.we) mem[ram_if.addr] <= ram_if.din;
      else begin
        rdata <= (fault_on && ram_if.addr == fault_addr && hits == fault_base + fault_nth - 1) ? 8'hFF : mem[ram_if.addr];
        if (ram_if.addr == fault_addr) hits <= hits + 1;
      end
    end
  end
  function automatic logic [DW-1:0] ev(input logic [DW-1:0] s, input int i);
    logic [DW-1:0] v;
    v = s + DW'(i);
    return INV ? ~v : v;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
    chk({n, "_pass"}, pass, 0);
    chk({n, "_err_addr"}, err_addr, 0);
    chk({n, "_err_data"}, err_data, 0);
    chk({n, "_en"}, ram_if.en, 0);
    chk({n, "_we"}, ram_if.we, 0);
    chk({n, "_addr"}, ram_if.addr, 0);
    chk({n, "_din"}, ram_if.din, 0);
  endtask
  // Monitor: pops the expected result whenever done rises and checks outcome and timing
  always @(negedge clk) begin
    exp_t e;
    if (ram_if.we && !ram_if.en) begin
      total++;
      bad++;
      $display("FAIL we_without_en: we=%0b en=%0b", ram_if.we, ram_if.en);
    end
    if (done && !done_q) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no result pending");
      end else begin
        e = q.pop_front();
        chk("pass", pass, e.p);
        chk("err_addr", err_addr, e.a);
        chk("err_data", err_data, e.d);
        chk("done_cycle", edges, e.e);
        chk("busy_at_done", busy, 0);
        chk("en_at_done", ram_if.en, 0);
      end
    end
    done_q <= done;
  end
  task automatic run(input logic [DW-1:0] s, input int p1, input int p2, input int ab,
                     input logic ep, input logic [AW-1:0] ea, input logic [DW-1:0] ed, input int ec);
    int c;
    logic fin;
    @(negedge clk);
    start = 1'b1;
    seed = s;
    t0 = edges;
    if (ab == 0) q.push_back('{ep, ea, ed, t0 + ec});
    fin = 1'b0;
    for (int i = 0; i < 300 && !fin; i++) begin
      @(negedge clk);
      c = edges - t0;
      start = (c == p1) || (c == p2);
      if (c == 1) begin
        chk("busy_c1", busy, 1);
        chk("done_clr_c1", done, 0);
        chk("en_c1", ram_if.en, 1);
        chk("we_c1", ram_if.we, 1);
        chk("addr_c1", ram_if.addr, 0);
        chk("din_c1", ram_if.din, s);
      end
      if (ab != 0 && c == ab) rst = 1'b1;
      if (ab != 0 && c == ab + 1) begin
        rst = 1'b0;
        chk_zero("abort");
        fin = 1'b1;
      end
      if (ab == 0 && c > 1 && done) fin = 1'b1;
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done within 300 cycles want done at cycle %0d", ec);
    end
    start = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    run(8'd32, 0, 0, 0, 1'b1, 4'd0, 8'd0, CLEAN);
    chk("mem0_s32", mem[0], ev(8'd32, 0));
    chk("mem7_s32", mem[7], ev(8'd32, 7));
    chk("mem15_s32", mem[15], ev(8'd32, 15));
    run(8'd250, 0, 0, 0, 1'b1, 4'd0, 8'd0, CLEAN);
    chk("mem0_s250", mem[0], ev(8'd250, 0));
    chk("mem5_s250", mem[5], ev(8'd250, 5));
    chk("mem6_s250", mem[6], ev(8'd250, 6));
    chk("mem15_s250", mem[15], ev(8'd250, 15));
    fault_on = 1'b1;
    fault_addr = 4'd5;
    fault_nth = 1;
    fault_base = hits;
    run(8'd32, 0, 0, 0, 1'b0, 4'd5, 8'hFF, N + 8);
    fault_on = 1'b0;
    run(8'd32, 0, 0, 7, 1'b0, 4'd0, 8'd0, 0);
    run(8'd0, 0, 0, 0, 1'b1, 4'd0, 8'd0, CLEAN);
    chk("mem3_s0", mem[3], ev(8'd0, 3));
    run(8'd32, 3, 20, 0, 1'b1, 4'd0, 8'd0, CLEAN);
    run(8'd32, 0, 0, 0, 1'b1, 4'd0, 8'd0, CLEAN);
    chk("mem15_again", mem[15], ev(8'd32, 15));
`ifdef IOB_RAM_SP_BIST_INV_EN
    chk("mem0_inv", mem[0], 8'hDF);
    chk("mem15_inv", mem[15], 8'hD0);
    fault_on = 1'b1;
    fault_addr = 4'd3;
    fault_nth = 2;
    fault_base = hits;
    run(8'd32, 0, 0, 0, 1'b0, 4'd3, 8'hFF, 3 * N + 7);
    fault_on = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iob_ram_sp_bist.md
Name: iob_ram_sp_bist

Overview:
Self-test initiator for single-port synchronous RAMs (iob_ram_sp family).
- Drives the RAM's en/we/addr/din side and consumes its dout.
- On a start pulse, writes an incrementing pattern to every word, reads every word back and compares.
- Reports done/pass plus the first failing address and data.
- Placed between the system controller and a RAM instance, or used stand-alone as a memory BIST.

Parameters:
DATA_W, 8, RAM word width in bits
ADDR_W, 4, RAM address width; N = 2**ADDR_W words tested

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin test; sampled only in IDLE
seed  input  DATA_W  first pattern value; latched on accepted start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  test finished; held until next accepted start or rst
pass  output  1  valid while done; 1 = no mismatch
err_addr  output  ADDR_W  address of the first mismatch; 0 if pass
err_data  output  DATA_W  data read at err_addr; 0 if pass
ram_en  output  1  RAM enable
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM address
ram_din  output  DATA_W  RAM write data
ram_dout  input  DATA_W  RAM read data, valid 1 cycle after a read access

Behaviour:
- Reset (synchronous): next state IDLE. All outputs read 0 from the cycle after the rst edge.
- Reset mid-operation aborts the test immediately. The RAM contents are left as-is.
- Pattern: exp(i) = (seed_latched + i) mod 2**DATA_W. Wraps silently; no overflow flag.
- FSM states: IDLE, WRITE, READ, CHECK, DONE. Accepted start at edge E0; cycle k means k cycles after E0.
- IDLE:
  - start=1 clears done, pass, err_addr and err_data, latches seed, and moves to WRITE.
  - start=0 holds state; done, pass and err_* keep their last values.
- WRITE, cycles 1..N:
  - ram_en=1, ram_we=1, ram_addr=i, ram_din=exp(i), for i = 0..N-1.
  - After address N-1, moves to READ. The address counter does not wrap.
- READ, cycles N+1..2N:
  - ram_en=1, ram_we=0, ram_addr=i, ram_din=0.
  - From cycle N+2, ram_dout is compared against exp(i-1) (registered expected/addr pipeline, 1-cycle latency).
  - After address N-1, moves to CHECK.
- CHECK, cycle 2N+1: ram_en=0; compares the last word (addr N-1).
- Mismatch in READ or CHECK:
  - Same cycle: ram_en forced 0. The next cycle issues no further accesses.
  - err_addr and err_data are registered; moves to DONE with pass=0.
  - Only the first mismatch is recorded.
- DONE:
  - On a clean run, entered at cycle 2N+2 with busy=0, done=1, pass=1.
  - Returns to IDLE on the same cycle; done/pass stay held in IDLE.
- busy is high for cycles 1..2N+1, or until the mismatch cycle inclusive.
- start while busy is ignored. A start in the same cycle as rst is ignored; rst wins.
- ram_we is never high when ram_en is low. All outputs are registered.

Optional Feature:
Macro IOB_RAM_SP_BIST_INV_EN.
- Defined:
  - After the first READ/CHECK pass with no mismatch, a second WRITE/READ/CHECK pass runs with pattern ~exp(i).
  - The second pass reuses the same states, with an internal phase bit.
  - Clean completion gives done at cycle 4N+3. The first CHECK cycle is followed directly by the second WRITE.
  - Mismatch handling is identical in both passes.
- Undefined: single pass only; no phase bit is synthesized.

Test Plan:
1. Default params, behavioural 1-cycle RAM model, seed=32, start 1 cycle:
   - RAM holds 32..47 at addr 0..15.
   - done=1 and pass=1 at cycle 34.
   - err_addr=0, err_data=0.
2. seed=250:
   - Written data 250..255, 0..9.
   - pass=1; no spurious error at the wrap point.
3. Bench forces ram_dout=8'hFF when reading addr 5, seed=32:
   - pass=0, err_addr=5, err_data=8'hFF.
   - ram_en=0 from the mismatch cycle onward.
   - done at cycle N+8=24.
4. rst asserted at cycle 7 (mid-WRITE):
   - Next cycle: all outputs 0, state IDLE.
   - A subsequent start with seed=0 passes with done at cycle 34.
5. start pulsed again at cycles 3 and 20:
   - Ignored; timing and results identical to scenario 1.
   - A start while done=1 in IDLE clears done and restarts.
6. With IOB_RAM_SP_BIST_INV_EN, seed=32:
   - Final RAM contents are ~(32..47), i.e. 8'hDF..8'hD0.
   - pass=1 at cycle 67.
   - A fault forced only in the second pass at addr 3 gives err_addr=3, pass=0.
